mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the MIPS datapath. It sequences one shared memory, one ALU and the regfile over several cycles per instruction.
//  Decodes the IR opcode and drives datapath select/write strobes each cycle; waits on a memory ready handshake with a timeout watchdog.
//  Sits between the IR/memory interface and the datapath muxes; replaces single-cycle control + PCControl.
// PARAMETERS
//  ALUOP_ADD    3'b000  ALU op code: add (PC+4, address calc, addi)
//  ALUOP_SUB    3'b001  ALU op code: subtract (beq/bne compare)
//  ALUOP_RTYPE  3'b010  ALU op code: decode from funct field
//  MEM_TIMEOUT  16      max cycles a memory access waits for mem_ready (>=2)
// PORTS
//  clock        in   1  system clock, all state changes on rising edge
//  reset        in   1  synchronous, active-low reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  mem_ready    in   1  memory has completed current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if branch condition true (zero, or !zero when branch_ne)
//  branch_ne    out  1  1 = bne sense for PCWriteCond
//  IorD         out  1  memory address: 0 = PC, 1 = ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  load IR from memory data
//  MemtoReg     out  1  regfile write data: 0 = ALUOut, 1 = MDR
//  RegDst       out  1  write register: 0 = rt, 1 = rd
//  RegWrite     out  1  regfile write enable
//  ALUSrcA      out  1  ALU A: 0 = PC, 1 = rs
//  ALUSrcB      out  2  ALU B: 00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUOp        out  3  to ula_control
//  PCSource     out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  instr_done   out  1  1-cycle pulse when an instruction retires
//  illegal_op   out  1  1-cycle pulse on unsupported opcode
//  bus_error    out  1  1-cycle pulse on memory timeout
//  state        out  4  current FSM state (debug)
// BEHAVIOUR
//  - Registered state; all other outputs are decoded from state (+mem_ready); unlisted outputs are 0.
//  - reset==0 at edge: state<=FETCH, wait counter<=0. While reset==0 every strobe/write/pulse output is forced 0.
//  - FETCH(0): IorD=0 MemRead=1 ALUSrcA=0 ALUSrcB=01 ADD PCSource=00. If mem_ready: IRWrite=PCWrite=1 -> DECODE.
//  - DECODE(1): ALUSrcA=0 ALUSrcB=11 ADD (precompute branch target). Dispatch: 000000->EXEC, 100011/101011->MEMADR, 000100/000101->BRANCH, 000010->JUMP, 001000->IEXEC, other->TRAP.
//  - MEMADR(2): ALUSrcA=1 ALUSrcB=10 ADD -> lw:MEMRD, sw:MEMWR.
//  - MEMRD(3): IorD=1 MemRead=1; mem_ready -> MEMWB.   MEMWB(4): RegDst=0 MemtoReg=1 RegWrite=1 -> FETCH.
//  - MEMWR(5): IorD=1 MemWrite=1; mem_ready -> FETCH (retire).
//  - EXEC(6): ALUSrcA=1 ALUSrcB=00 RTYPE -> ALUWB(7): RegDst=1 MemtoReg=0 RegWrite=1 -> FETCH.
//  - BRANCH(8): ALUSrcA=1 ALUSrcB=00 SUB PCSource=01 PCWriteCond=1 branch_ne=(opcode==000101) -> FETCH.
//  - JUMP(9): PCSource=10 PCWrite=1 -> FETCH.
//  - IEXEC(10): ALUSrcA=1 ALUSrcB=10 ADD -> IWB(11): RegDst=0 MemtoReg=0 RegWrite=1 -> FETCH.
//  - TRAP(12): illegal_op=1, no writes -> FETCH. PC already advanced; execution continues at next word.
//  - instr_done=1 in MEMWB, ALUWB, IWB, BRANCH, JUMP, and MEMWR when mem_ready. TRAP does not retire.
//  - Cycles/instr with mem_ready=1: R/addi 4, lw 5, sw 4, beq/bne/j 3.
//  - Wait counter: cleared on entry to FETCH/MEMRD/MEMWR, +1 each waiting cycle without mem_ready.
//  - Timeout: in a wait state, counter==MEM_TIMEOUT-1 and mem_ready==0 -> bus_error=1 that cycle, state<=FETCH. Strobes stay asserted that cycle; no IRWrite/PCWrite/RegWrite. FETCH timeout re-fetches same PC.
//  - mem_ready with counter==MEM_TIMEOUT-1: ready wins, no bus_error.
//  - mem_ready ignored outside FETCH/MEMRD/MEMWR. Unused encodings 13-15 -> FETCH next cycle, all outputs 0.
//  - Reset mid-instruction aborts it; no partial register write, next cycle is FETCH.
// TESTING
//  1. reset=0 3 cycles, then 1; mem_ready=1, opcode=000000 -> states 0,1,6,7,0; RegWrite=1,RegDst=1 only in state 7; instr_done in state 7.
//  2. opcode=100011, mem_ready low 2 cycles in MEMRD -> MemRead=IorD=1 for 3 cycles; state 4 has RegWrite=MemtoReg=1; 7 cycles total.
//  3. opcode=000101 -> BRANCH: PCWriteCond=1, branch_ne=1, ALUOp=001, PCSource=01, then FETCH; opcode=000100 -> branch_ne=0.
//  4. MEM_TIMEOUT=4, opcode=101011, mem_ready=0 -> MemWrite=1 for 4 cycles, bus_error on 4th, next state FETCH, instr_done never.
//  5. opcode=111111 -> DECODE, TRAP with illegal_op=1 one cycle, no RegWrite/PCWrite, then FETCH.
//  6. reset=0 during MEMRD -> outputs 0 while reset low; first cycle after release is FETCH with MemRead=1, IorD=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS datapath/memory.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       branch_ne;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op, bus_error, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op, bus_error, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences shared memory, ALU and regfile per instruction,
// with a memory-ready wait counter and timeout watchdog.
module mips_multicycle_ctrl #(
  parameter logic [2:0]  ALUOP_ADD   = 3'b000,
  parameter logic [2:0]  ALUOP_SUB   = 3'b001,
  parameter logic [2:0]  ALUOP_RTYPE = 3'b010,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clock,
  input logic                   reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] IEXEC  = 4'd10;
  localparam logic [3:0] IWB    = 4'd11;
  localparam logic [3:0] TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int unsigned  CW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state, next_state;
  logic [CW-1:0] cnt;
  logic          waiting, timeout;

  always_comb begin
    waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    timeout = waiting && !bus.mem_ready && (cnt == LAST);
  end

  always_comb begin
    next_state      = FETCH;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = ALUOP_ADD;
    bus.PCSource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.bus_error   = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          next_state  = DECODE;
        end else begin
          bus.bus_error = timeout;
          next_state    = FETCH;
        end
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_RTYPE:      next_state = EXEC;
          OP_LW, OP_SW:  next_state = MEMADR;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_J:          next_state = JUMP;
          OP_ADDI:       next_state = IEXEC;
          default:       next_state = TRAP;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        next_state  = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready)    next_state = MEMWB;
        else if (timeout)     begin bus.bus_error = 1'b1; next_state = FETCH; end
        else                  next_state = MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg   = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready)    bus.instr_done = 1'b1;
        else if (timeout)     bus.bus_error = 1'b1;
        else                  next_state = MEMWR;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_RTYPE;
        next_state  = ALUWB;
      end
      ALUWB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALUOP_SUB;
        bus.PCSource    = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.branch_ne   = (bus.opcode == OP_BNE);
        bus.instr_done  = 1'b1;
      end
      JUMP: begin
        bus.PCSource   = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
      end
      IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        next_state  = IWB;
      end
      IWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      TRAP:    bus.illegal_op = 1'b1;
      default: next_state = FETCH;
    endcase
    // Reset overrides every decoded output so an aborted instruction cannot write.
    if (!reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.branch_ne   = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 3'b000;
      bus.PCSource    = 2'b00;
      bus.instr_done  = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.bus_error   = 1'b0;
    end
  end

  assign bus.state = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (waiting && !bus.mem_ready && !timeout) ? cnt + CW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven cycle-by-cycle check of the multicycle controller's state and control outputs.
module tb_mips_multicycle_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic done, ill, berr;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04,
                         BNE = 6'h05, J = 6'h02, ADDI = 6'h08, BAD = 6'h3f;

  localparam outs_t RST0      = '{st:4'd0, default:'0};
  localparam outs_t RST3      = '{st:4'd3, default:'0};
  localparam outs_t FETCH_W   = '{st:4'd0, mrd:1'b1, srcb:2'b01, default:'0};
  localparam outs_t FETCH_RDY = '{st:4'd0, mrd:1'b1, srcb:2'b01, irw:1'b1, pcw:1'b1, default:'0};
  localparam outs_t FETCH_TO  = '{st:4'd0, mrd:1'b1, srcb:2'b01, berr:1'b1, default:'0};
  localparam outs_t DECODE    = '{st:4'd1, srcb:2'b11, default:'0};
  localparam outs_t MEMADR    = '{st:4'd2, srca:1'b1, srcb:2'b10, default:'0};
  localparam outs_t MEMRD     = '{st:4'd3, iord:1'b1, mrd:1'b1, default:'0};
  localparam outs_t MEMRD_TO  = '{st:4'd3, iord:1'b1, mrd:1'b1, berr:1'b1, default:'0};
  localparam outs_t MEMWB     = '{st:4'd4, m2r:1'b1, rw:1'b1, done:1'b1, default:'0};
  localparam outs_t MEMWR     = '{st:4'd5, iord:1'b1, mwr:1'b1, default:'0};
  localparam outs_t MEMWR_RDY = '{st:4'd5, iord:1'b1, mwr:1'b1, done:1'b1, default:'0};
  localparam outs_t MEMWR_TO  = '{st:4'd5, iord:1'b1, mwr:1'b1, berr:1'b1, default:'0};
  localparam outs_t EXEC      = '{st:4'd6, srca:1'b1, aluop:3'b010, default:'0};
  localparam outs_t ALUWB     = '{st:4'd7, rdst:1'b1, rw:1'b1, done:1'b1, default:'0};
  localparam outs_t BR_EQ     = '{st:4'd8, srca:1'b1, aluop:3'b001, pcsrc:2'b01, pcwc:1'b1, done:1'b1, default:'0};
  localparam outs_t BR_NE     = '{st:4'd8, srca:1'b1, aluop:3'b001, pcsrc:2'b01, pcwc:1'b1, bne:1'b1, done:1'b1, default:'0};
  localparam outs_t JUMP      = '{st:4'd9, pcsrc:2'b10, pcw:1'b1, done:1'b1, default:'0};
  localparam outs_t IEXEC     = '{st:4'd10, srca:1'b1, srcb:2'b10, default:'0};
  localparam outs_t IWB       = '{st:4'd11, rw:1'b1, done:1'b1, default:'0};
  localparam outs_t TRAP      = '{st:4'd12, ill:1'b1, default:'0};

  vec_t  tbl[$];
  outs_t sb[$];

  function automatic void add(input logic rst, input logic [5:0] op, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.st = bus.state;        a.pcw = bus.PCWrite;   a.pcwc = bus.PCWriteCond;
    a.bne = bus.branch_ne;   a.iord = bus.IorD;     a.mrd = bus.MemRead;
    a.mwr = bus.MemWrite;    a.irw = bus.IRWrite;   a.m2r = bus.MemtoReg;
    a.rdst = bus.RegDst;     a.rw = bus.RegWrite;   a.srca = bus.ALUSrcA;
    a.srcb = bus.ALUSrcB;    a.aluop = bus.ALUOp;   a.pcsrc = bus.PCSource;
    a.done = bus.instr_done; a.ill = bus.illegal_op; a.berr = bus.bus_error;
    return a;
  endfunction

  task automatic step(input int idx, input vec_t v);
    outs_t e, a;
    @(negedge clock);
    reset         = v.rst;
    bus.opcode    = v.op;
    bus.mem_ready = v.rdy;
    sb.push_back(v.exp);
    #1;
    e = sb.pop_front();
    a = actual();
    n_checks++;
    if (a !== e) begin
      n_fails++;
      $display("FAIL cycle_vec[%0d] state=%0d outs got=%h expected=%h", idx, e.st, a, e);
    end
  endtask

  initial begin
    bus.opcode    = R;
    bus.mem_ready = 1'b1;
    @(posedge clock);

    // R-type after a 3-cycle reset
    add(0, R, 1, RST0); add(0, R, 1, RST0);
    add(1, R, 1, FETCH_RDY); add(1, R, 1, DECODE); add(1, R, 1, EXEC); add(1, R, 1, ALUWB);
    // lw with two wait cycles in MEMRD; mem_ready ignored in DECODE/MEMADR
    add(1, LW, 1, FETCH_RDY); add(1, LW, 0, DECODE); add(1, LW, 0, MEMADR);
    add(1, LW, 0, MEMRD); add(1, LW, 0, MEMRD); add(1, LW, 1, MEMRD); add(1, LW, 1, MEMWB);
    // bne, beq, j, addi, sw
    add(1, BNE, 1, FETCH_RDY); add(1, BNE, 1, DECODE); add(1, BNE, 1, BR_NE);
    add(1, BEQ, 1, FETCH_RDY); add(1, BEQ, 1, DECODE); add(1, BEQ, 1, BR_EQ);
    add(1, J, 1, FETCH_RDY); add(1, J, 1, DECODE); add(1, J, 1, JUMP);
    add(1, ADDI, 1, FETCH_RDY); add(1, ADDI, 1, DECODE); add(1, ADDI, 1, IEXEC); add(1, ADDI, 1, IWB);
    add(1, SW, 1, FETCH_RDY); add(1, SW, 1, DECODE); add(1, SW, 1, MEMADR); add(1, SW, 1, MEMWR_RDY);

    foreach (tbl[i]) step(i, tbl[i]);
    tbl.delete();

    // sw timeout: MemWrite 4 cycles, bus_error on the 4th, no retire
    add(1, SW, 1, FETCH_RDY); add(1, SW, 1, DECODE); add(1, SW, 0, MEMADR);
    for (int k = 0; k < 3; k++) add(1, SW, 0, MEMWR);
    add(1, SW, 0, MEMWR_TO);
    // FETCH timeout re-fetches, then ready arriving on the last wait cycle wins
    for (int k = 0; k < 3; k++) add(1, BAD, 0, FETCH_W);
    add(1, BAD, 0, FETCH_TO);
    for (int k = 0; k < 3; k++) add(1, BAD, 0, FETCH_W);
    add(1, BAD, 1, FETCH_RDY);
    // illegal opcode traps for one cycle
    add(1, BAD, 1, DECODE); add(1, BAD, 1, TRAP);
    // reset asserted in MEMRD aborts the load
    add(1, LW, 1, FETCH_RDY); add(1, LW, 1, DECODE); add(1, LW, 1, MEMADR); add(1, LW, 0, MEMRD);
    add(0, LW, 1, RST3); add(0, LW, 1, RST0);
    add(1, LW, 0, FETCH_W);
    // MEMRD timeout returns to FETCH without a register write
    add(1, LW, 1, FETCH_RDY); add(1, LW, 1, DECODE); add(1, LW, 1, MEMADR);
    for (int k = 0; k < 3; k++) add(1, LW, 0, MEMRD);
    add(1, LW, 0, MEMRD_TO);
    add(1, R, 1, FETCH_RDY); add(1, R, 1, DECODE);

    foreach (tbl[i]) step(100 + i, tbl[i]);

    if (sb.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
